// File: rtl/act_pool_pkg.sv
// Shared definitions for the activation / 2x2 max-pool unit.
// Holds datapath widths, line-buffer depth, the control FSM state type and
// small arithmetic helpers used on post-ReLU (unsigned) values.
package act_pool_pkg;

    localparam int MAX_OFMAP = 31;
    localparam int LB_DEPTH  = 16;
    localparam int DATA_W    = 8;
    localparam int ADDR_W    = 10;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Negative int8 values clamp to zero; the result is then treated as unsigned.
    function automatic logic [DATA_W-1:0] relu(input logic [DATA_W-1:0] x);
        return x[DATA_W-1] ? '0 : x;
    endfunction

    // Unsigned max; inputs are always post-ReLU so no sign handling is needed.
    function automatic logic [DATA_W-1:0] umax(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Pool line buffer: holds the horizontal pair maxima of an even row so the
// following odd row can complete each 2x2 window.
// Ports:
//   clk_i     rising-edge clock
//   we_i      write enable
//   waddr_i   write index (pooled column)
//   wdata_i   write data
//   raddr_i   asynchronous read index
//   rdata_o   asynchronous read data
// Contents are not reset; every entry is written in an even row before the
// odd row reads it.
module pool_line_buf
    import act_pool_pkg::*;
(
    input  logic                        clk_i,
    input  logic                        we_i,
    input  logic [$clog2(LB_DEPTH)-1:0] waddr_i,
    input  logic [DATA_W-1:0]           wdata_i,
    input  logic [$clog2(LB_DEPTH)-1:0] raddr_i,
    output logic [DATA_W-1:0]           rdata_o
);

    logic [DATA_W-1:0] mem_q [LB_DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/act_pool_unit.sv
// Activation and pooling unit: applies ReLU to a raster stream of int8 conv
// results and optionally performs 2x2 / stride-2 max pooling.
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   ofmap_size_i        feature map side S (1..31), captured while idle
//   pool_en_i           1 = ReLU + max-pool, 0 = ReLU bypass, captured while idle
//   conv_valid_i        input sample strobe (no back-pressure)
//   conv_last_i         final sample of the map
//   conv_result_i       signed int8 sample
//   addr_i              raster index of the sample, checked against internal counters
//   out_valid_o         one-cycle output strobe
//   out_data_o          activated (pooled) value
//   out_addr_o          output raster index
//   out_last_o          final output of the map
//   err_o               sticky sequence error flag
module act_pool_unit
    import act_pool_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        ofmap_size_i,
    input  logic              pool_en_i,
    input  logic              conv_valid_i,
    input  logic              conv_last_i,
    input  logic [DATA_W-1:0] conv_result_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic [ADDR_W-1:0] out_addr_o,
    output logic              out_last_o,
    output logic              err_o
);

    localparam int LbIdxW = $clog2(LB_DEPTH);

    state_e state_q, state_d;

    logic [4:0]        size_q;
    logic              pool_q;
    logic [4:0]        row_q, row_d;
    logic [4:0]        col_q, col_d;
    logic [DATA_W-1:0] pair_q, pair_d;
    logic              err_q, err_d;

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic              out_last_q, out_last_d;

    // Config in effect for this cycle: live inputs while idle (the first sample
    // of a map is processed in the IDLE cycle), frozen copies while running.
    logic [4:0]        size_eff;
    logic              pool_eff;
    logic [4:0]        size_m1;
    logic [4:0]        half_p;
    logic [4:0]        two_p;
    logic [4:0]        two_p_m1;
    logic              in_window;
    logic [DATA_W-1:0] relu_x;
    logic [ADDR_W-1:0] exp_addr;
    logic [ADDR_W-1:0] pool_addr;

    logic              lb_we;
    logic [DATA_W-1:0] lb_wdata;
    logic [LbIdxW-1:0] lb_idx;
    logic [DATA_W-1:0] lb_rdata;

    assign size_eff  = (state_q == IDLE) ? ofmap_size_i : size_q;
    assign pool_eff  = (state_q == IDLE) ? pool_en_i : pool_q;
    assign size_m1   = size_eff - 5'd1;
    assign half_p    = {1'b0, size_eff[4:1]};
    assign two_p     = {size_eff[4:1], 1'b0};
    assign two_p_m1  = two_p - 5'd1;
    // Odd S leaves the last row/column outside any 2x2 window; S=1 keeps nothing.
    assign in_window = (row_q < two_p) && (col_q < two_p);
    assign relu_x    = relu(conv_result_i);
    assign exp_addr  = ADDR_W'(row_q) * ADDR_W'(size_eff) + ADDR_W'(col_q);
    assign pool_addr = ADDR_W'(row_q[4:1]) * ADDR_W'(half_p) + ADDR_W'(col_q[4:1]);
    assign lb_idx    = col_q[4:1];

    pool_line_buf u_line_buf (
        .clk_i   (clk),
        .we_i    (lb_we),
        .waddr_i (lb_idx),
        .wdata_i (lb_wdata),
        .raddr_i (lb_idx),
        .rdata_o (lb_rdata)
    );

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        pair_d      = pair_q;
        err_d       = err_q;
        lb_we       = 1'b0;
        lb_wdata    = umax(pair_q, relu_x);
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        out_addr_d  = out_addr_q;
        out_last_d  = out_last_q;

        if (conv_valid_i) begin
            if (state_q == IDLE) begin
                state_d = RUN;
            end

            if (addr_i != exp_addr) begin
                err_d = 1'b1;
            end

            // Position tracking; a last marker always ends the map, even if misplaced.
            if (conv_last_i) begin
                if ((row_q != size_m1) || (col_q != size_m1)) begin
                    err_d = 1'b1;
                end
                row_d   = '0;
                col_d   = '0;
                state_d = IDLE;
            end else if (col_q == size_m1) begin
                col_d = '0;
                row_d = row_q + 5'd1;
            end else begin
                col_d = col_q + 5'd1;
            end

            if (pool_eff) begin
                if (in_window) begin
                    unique case ({row_q[0], col_q[0]})
                        2'b00: pair_d = relu_x;
                        2'b01: lb_we = 1'b1;
                        2'b10: pair_d = umax(lb_rdata, relu_x);
                        2'b11: begin
                            out_valid_d = 1'b1;
                            out_data_d  = umax(pair_q, relu_x);
                            out_addr_d  = pool_addr;
                            out_last_d  = (row_q == two_p_m1) && (col_q == two_p_m1);
                        end
                        default: ;
                    endcase
                end
            end else begin
                out_valid_d = 1'b1;
                out_data_d  = relu_x;
                out_addr_d  = addr_i;
                out_last_d  = conv_last_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            size_q      <= '0;
            pool_q      <= 1'b0;
            row_q       <= '0;
            col_q       <= '0;
            pair_q      <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            if (state_q == IDLE) begin
                size_q <= ofmap_size_i;
                pool_q <= pool_en_i;
            end
            row_q       <= row_d;
            col_q       <= col_d;
            pair_q      <= pair_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_addr_q  <= out_addr_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_addr_o  = out_addr_q;
    assign out_last_o  = out_last_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_act_pool_unit.sv
// Scoreboard bench for act_pool_unit: the driver pushes the expected output
// for each sample that should produce one, the monitor pops and compares.
module tb_act_pool_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] ofmap_size_i;
    logic       pool_en_i;
    logic       conv_valid_i;
    logic       conv_last_i;
    logic [7:0] conv_result_i;
    logic [9:0] addr_i;
    logic       out_valid_o;
    logic [7:0] out_data_o;
    logic [9:0] out_addr_o;
    logic       out_last_o;
    logic       err_o;

    act_pool_unit dut (
        .clk           (clk),
        .rst           (rst),
        .ofmap_size_i  (ofmap_size_i),
        .pool_en_i     (pool_en_i),
        .conv_valid_i  (conv_valid_i),
        .conv_last_i   (conv_last_i),
        .conv_result_i (conv_result_i),
        .addr_i        (addr_i),
        .out_valid_o   (out_valid_o),
        .out_data_o    (out_data_o),
        .out_addr_o    (out_addr_o),
        .out_last_o    (out_last_o),
        .err_o         (err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic [9:0] a;
        logic       l;
        int         c;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   out_cnt = 0;
    int   n_checks = 0;
    int   n_errs = 0;
    int   vals[1024];

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int relu_m(input int v);
        return (v < 0) ? 0 : v;
    endfunction

    always @(negedge clk) begin
        if (out_valid_o) begin
            exp_t e;
            out_cnt++;
            check("sb_has_entry", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("out_data", 32'(out_data_o), 32'(e.d));
                check("out_addr", 32'(out_addr_o), 32'(e.a));
                check("out_last", 32'(out_last_o), 32'(e.l));
                check("out_cycle", 32'(cyc), 32'(e.c));
            end
        end
    end

    // Drive n samples back-to-back; addresses from index `skip` onward are bumped by one.
    task automatic run_map(input int s, input bit pool, input int n, input int skip);
        int p;
        p = s / 2;
        ofmap_size_i = 5'(s);
        pool_en_i    = pool;
        for (int k = 0; k < n; k++) begin
            int   r;
            int   c;
            int   m;
            bit   last;
            exp_t e;
            r    = k / s;
            c    = k % s;
            last = (k == s * s - 1);
            conv_valid_i  = 1'b1;
            conv_result_i = 8'(vals[k]);
            addr_i        = 10'(k + ((skip >= 0 && k >= skip) ? 1 : 0));
            conv_last_i   = last;
            if (pool) begin
                if (r < 2 * p && c < 2 * p && (r % 2) == 1 && (c % 2) == 1) begin
                    m = relu_m(vals[k]);
                    if (relu_m(vals[k - 1]) > m) m = relu_m(vals[k - 1]);
                    if (relu_m(vals[k - s]) > m) m = relu_m(vals[k - s]);
                    if (relu_m(vals[k - s - 1]) > m) m = relu_m(vals[k - s - 1]);
                    e.d = 8'(m);
                    e.a = 10'((r / 2) * p + c / 2);
                    e.l = (r == 2 * p - 1) && (c == 2 * p - 1);
                    e.c = cyc + 1;
                    sb.push_back(e);
                end
            end else begin
                e.d = 8'(relu_m(vals[k]));
                e.a = addr_i;
                e.l = last;
                e.c = cyc + 1;
                sb.push_back(e);
            end
            @(posedge clk);
            #1;
            // Config changes mid-map must have no effect.
            if (k == 0) begin
                ofmap_size_i = 5'd7;
                pool_en_i    = !pool;
            end
        end
        conv_valid_i = 1'b0;
        conv_last_i  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", 32'(sb.size()), 0);
        sb.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_valid", 32'(out_valid_o), 0);
        check("rst_data", 32'(out_data_o), 0);
        check("rst_addr", 32'(out_addr_o), 0);
        check("rst_last", 32'(out_last_o), 0);
        check("rst_err", 32'(err_o), 0);
    endtask

    task automatic fill_ramp(input int n);
        for (int i = 0; i < n; i++) vals[i] = i + 1;
    endtask

    initial begin
        int base;
        rst           = 1'b1;
        ofmap_size_i  = 5'd4;
        pool_en_i     = 1'b1;
        conv_valid_i  = 1'b0;
        conv_last_i   = 1'b0;
        conv_result_i = 8'd0;
        addr_i        = 10'd0;
        @(posedge clk);
        #1;
        do_reset();

        // S=4 pool ramp: 6, 8, 14, 16
        fill_ramp(16);
        base = out_cnt;
        run_map(4, 1'b1, 16, -1);
        check("s4_pool_count", 32'(out_cnt - base), 4);
        check("s4_pool_err", 32'(err_o), 0);

        // S=4 pool all negative
        for (int i = 0; i < 16; i++) vals[i] = -5;
        base = out_cnt;
        run_map(4, 1'b1, 16, -1);
        check("s4_neg_count", 32'(out_cnt - base), 4);

        // S=4 bypass two samples, then abandon the map
        vals[0] = -3;
        vals[1] = 7;
        base = out_cnt;
        run_map(4, 1'b0, 2, -1);
        check("bypass_count", 32'(out_cnt - base), 2);
        do_reset();

        // S=5 pool ramp: 7, 9, 17, 19; edge row/col discarded
        fill_ramp(25);
        base = out_cnt;
        run_map(5, 1'b1, 25, -1);
        check("s5_pool_count", 32'(out_cnt - base), 4);
        check("s5_pool_err", 32'(err_o), 0);

        // S=1 pool produces nothing
        vals[0] = 9;
        base = out_cnt;
        run_map(1, 1'b1, 1, -1);
        check("s1_pool_count", 32'(out_cnt - base), 0);

        // Address skip sets sticky error; last still returns to idle
        fill_ramp(16);
        run_map(4, 1'b1, 16, 5);
        check("skip_err_set", 32'(err_o), 1);
        base = out_cnt;
        run_map(4, 1'b1, 16, -1);
        check("after_err_count", 32'(out_cnt - base), 4);
        check("err_sticky", 32'(err_o), 1);
        do_reset();

        // Reset after sample 9, then a fresh map
        run_map(4, 1'b1, 9, -1);
        do_reset();
        base = out_cnt;
        run_map(4, 1'b1, 16, -1);
        check("fresh_count", 32'(out_cnt - base), 4);
        check("fresh_err", 32'(err_o), 0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/act_pool_unit.md
ACT_POOL_UNIT -- requirements
Module: act_pool_unit

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset.
REQ-002 The ports SHALL be as follows, listed as name, direction, width, meaning:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- ofmap_size_i  in  5  output feature map side S, legal range 1..31; sampled in IDLE.
- pool_en_i  in  1  1 = ReLU plus 2x2/stride-2 max-pool; 0 = ReLU only (bypass); sampled in IDLE.
- conv_valid_i  in  1  conv result present; there is no back-pressure.
- conv_last_i  in  1  final conv result of the map.
- conv_result_i  in  8  signed int8 conv result.
- addr_i  in  10  raster index row*S+col of conv_result_i.
- out_valid_o  out  1  output data valid, one-cycle pulse.
- out_data_o  out  8  activated, pooled value.
- out_addr_o  out  10  output raster index.
- out_last_o  out  1  final output of the map.
- err_o  out  1  sticky sequence error flag.

Function
REQ-003 ReLU SHALL map negative conv_result_i to 8'd0 and pass non-negative values unchanged.
REQ-004 The FSM SHALL have two states: IDLE and RUN. In IDLE, conv_valid_i moves the FSM to RUN, and the sample is processed in that cycle. In RUN, an accepted conv_last_i returns the FSM to IDLE.
REQ-005 Internal row and column counters (5 bits each) SHALL track the expected position. They start at 0, advance on each conv_valid_i, and the column wraps at S-1 with a row increment.
REQ-006 In bypass mode, each input SHALL produce out_valid_o exactly 1 cycle later, with out_data_o = ReLU(x), out_addr_o = addr_i and out_last_o = conv_last_i.
REQ-007 In pool mode, with P = floor(S/2), samples with row >= 2P or col >= 2P SHALL be discarded (odd S drops the last row and column).
REQ-008 Even-row handling in pool mode:
- On an even column, the ReLU value SHALL go to a pair register.
- On an odd column, max(pair, ReLU) SHALL be written to linebuf[col>>1].
REQ-009 Odd-row handling in pool mode:
- On an even column, the pair register SHALL be set to max(linebuf[col>>1], ReLU).
- On an odd column, the block SHALL emit max(pair, ReLU) 1 cycle later, with out_addr_o = (row>>1)*P + (col>>1).
REQ-010 In pool mode, out_last_o SHALL assert with the output for row = 2P-1, col = 2P-1. S = 1 SHALL produce no output.
REQ-011 All max comparisons SHALL be unsigned on post-ReLU values, so no width growth occurs.
REQ-012 err_o SHALL set, and remain set until reset, when either condition holds:
- addr_i differs from the counter-derived index on a valid sample.
- conv_last_i arrives at a position other than (S-1, S-1).
REQ-013 On conv_last_i, the counters SHALL clear regardless of error, and the FSM SHALL go to IDLE.
REQ-014 ofmap_size_i and pool_en_i changes during RUN SHALL be ignored until the next IDLE.
REQ-015 conv_valid_i is 1 for at most one sample per cycle. Back-to-back samples every cycle SHALL be sustained with no loss.

Reset
REQ-016 Reset SHALL force the following values: FSM to IDLE; counters 0; pair register 0; out_valid_o 0; out_data_o 0; out_addr_o 0; out_last_o 0; err_o 0.
REQ-017 Line buffer contents SHALL NOT require reset, and they SHALL never be read before being written within a map.
REQ-018 Reset asserted mid-map SHALL abandon the map: no further outputs, and the next conv_valid_i starts a new map at position (0,0).

Structure
REQ-019 Package act_pool_pkg SHALL hold the following:
- MAX_OFMAP = 31.
- LB_DEPTH = 16.
- DATA_W = 8.
- ADDR_W = 10.
- The state enum {IDLE, RUN}.
REQ-020 The line buffer SHALL be a sub-module pool_line_buf: 16 x 8 bits, 1 write port, 1 asynchronous read port, read/write to the same index in different rows only.
REQ-021 Sixteen instances SHALL be placed per array, one per accumulator column, by a parent wrapper outside this block.

Verification
REQ-022 The bench SHALL cover the following directed scenarios:
- S=4, pool, inputs 1..16 raster, all positive -> 4 outputs: 6, 8, 14, 16 at addr 0..3; last with addr 3; err_o 0.
- S=4, pool, all inputs -5 -> 4 outputs of 0.
- S=4, bypass, inputs {-3, 7} -> outputs 0, 7 one cycle after each input, addr echoed.
- S=5, pool, inputs 1..25 -> P=2 outputs 7, 9, 17, 19; row 4 and col 4 discarded; last on the 4th output; no output from input 25.
- S=4, pool, addr_i skips 5 -> err_o sets and stays 1; conv_last_i at the 16th sample still returns to IDLE.
- S=4, rst asserted after sample 9, then a fresh map of 1..16 -> only the fresh map's 4 outputs, with values identical to the first scenario.
